nios_system_onchip_memory_arbiter: RTL and testbench

Shares one single-port on-chip RAM (32-bit, 32768 words, byte enables, 1-cycle read latency) between two Avalon-MM masters.
- Arbitration is round-robin with per-master waitrequest and readdatavalid.
- A built-in clear engine zero-fills the whole RAM on command.
- Sits between the two master-side interconnect ports and the RAM's single slave port.

---
 rtl/nios_system_onchip_memory_arbiter_pkg.sv | 16 +
 rtl/nios_system_onchip_memory_arbiter_if.sv | 27 ++
 rtl/nios_system_onchip_memory_arbiter_rr_arb2.sv | 35 +++
 rtl/nios_system_onchip_memory_arbiter.sv | 136 +++++++++++++
 tb/tb_nios_system_onchip_memory_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_onchip_memory_arbiter_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package nios_system_mem_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

endpackage

// File: rtl/nios_system_onchip_memory_arbiter_if.sv
// Avalon-MM master-side port bundle. The arbiter sits on the slave modport.
interface nios_system_onchip_memory_arbiter_if
    import nios_system_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_onchip_memory_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. On a conflict the requester that did
// not win last time is granted; the history only moves when a grant occurs.
module nios_system_rr_arb2
    import nios_system_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    // last_grant resets to M1 so that M0 wins the first conflict
    logic last_grant;

    // Combinational grant, suppressed entirely when advance is low
    always_comb begin
        grant = 2'b00;
        if (advance) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Remember which master was last served
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[M1];
        end
    end
endmodule

// File: rtl/nios_system_onchip_memory_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin
// arbitration, and zero-fills the RAM on command via a built-in clear engine.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal arbitration, one transfer per cycle
// ST_CLEAR | zero-fill sweep, one word per cycle, both masters stalled
module nios_system_onchip_memory_arbiter
    import nios_system_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                                clk,
    input  logic                                reset,
    nios_system_onchip_memory_arbiter_if.slave  m0,
    nios_system_onchip_memory_arbiter_if.slave  m1,
    input  logic                                clear_start,
    output logic                                clear_busy,
    output logic                                clear_done,
    output logic [ADDR_W-1:0]                   mem_address,
    output logic [BE_W-1:0]                     mem_byteenable,
    output logic                                mem_chipselect,
    output logic                                mem_write,
    output logic [DATA_W-1:0]                   mem_writedata,
    input  logic [DATA_W-1:0]                   mem_readdata
);
    // One spare counter bit keeps DEPTH == 2**ADDR_W from wrapping to zero
    localparam int             CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] clr_cnt;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             gnt_write;
    logic             gnt_read;
    logic             rd_valid;
    logic             rd_owner;

    // A master asserting read and write together is treated as a write
    assign req = {m1.read | m1.write, m0.read | m0.write};

    nios_system_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (state == ST_IDLE),
        .grant   (grant)
    );

    assign gnt_write = (grant[M0] & m0.write) | (grant[M1] & m1.write);
    assign gnt_read  = (|grant) & ~gnt_write;

    assign m0.waitrequest = req[M0] & ~grant[M0];
    assign m1.waitrequest = req[M1] & ~grant[M1];

    // RAM port mux: clear sweep, granted master, or idle (m0 values, deselected)
    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (state == ST_CLEAR) begin
            mem_address    = clr_cnt[ADDR_W-1:0];
            mem_byteenable = '1;
            mem_writedata  = '0;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end else if (grant[M1]) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            mem_chipselect = 1'b1;
            mem_write      = gnt_write;
        end else if (grant[M0]) begin
            mem_chipselect = 1'b1;
            mem_write      = gnt_write;
        end
    end

    // Sequencer: idle arbitration vs. clear sweep, with done pulse on exit
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CNT_LAST) begin
                        state      <= ST_IDLE;
                        clr_cnt    <= '0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign clear_busy = (state == ST_CLEAR);

    // Track who owns the read data returning next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_valid <= gnt_read;
            if (gnt_read) begin
                rd_owner <= grant[M1];
            end
        end
    end

    assign m0.readdatavalid = rd_valid & (rd_owner == 1'b0);
    assign m1.readdatavalid = rd_valid & (rd_owner == 1'b1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
// Bench for the two-master RAM arbiter: directed vector table, clear and
// reset corner sequences, then random traffic against a reference model.
module tb_nios_system_onchip_memory_arbiter;
    localparam int AW    = 8;
    localparam int NW    = 1 << AW;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;

    nios_system_onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(32), .BE_W(4)) m0_if ();
    nios_system_onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(32), .BE_W(4)) m1_if ();

    nios_system_onchip_memory_arbiter #(
        .ADDR_W(AW), .DATA_W(32), .BE_W(4), .DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .clear_done     (clear_done),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pre(input int i);
        if (i >= 'hA0 && i <= 'hA5) return 32'hCAFE_0000 | 32'(i);
        if (i == 'h20) return 32'hFFFF_FFFF;
        return 32'h5A5A_0000 | 32'(i);
    endfunction

    // Behavioural single-port RAM with one-cycle read latency
    logic [31:0] ram [NW];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < NW; i++) ram[i] = pre(i);
            ram_loaded = 1'b1;
        end
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] = mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: priority holder, pending-read queue, shadow memory
    typedef struct { int owner; logic [31:0] data; } rd_item_t;
    rd_item_t    rq[$];
    logic [31:0] ref_mem [NW];
    int          prio;
    bit          mclr;
    int          cidx;
    bit          exp_done;
    bit          mvalid;

    task automatic model_step();
        logic r0, r1, wr;
        logic [AW-1:0] a;
        logic [3:0] be;
        logic [31:0] wd, mask;
        int g;
        rd_item_t it;
        r0 = m0_if.read | m0_if.write;
        r1 = m1_if.read | m1_if.write;
        if (mvalid) begin
            chk("clear_busy", clear_busy, mclr);
            chk("clear_done", clear_done, exp_done);
            if (rq.size() > 0) begin
                it = rq.pop_front();
                chk("m0_readdatavalid", m0_if.readdatavalid, it.owner == 0);
                chk("m1_readdatavalid", m1_if.readdatavalid, it.owner == 1);
                chk("readdata", mem_readdata, it.data);
            end else begin
                chk("m0_readdatavalid", m0_if.readdatavalid, 0);
                chk("m1_readdatavalid", m1_if.readdatavalid, 0);
            end
        end
        if (mclr) begin
            if (mvalid) begin
                chk("clr m0_waitrequest", m0_if.waitrequest, r0);
                chk("clr m1_waitrequest", m1_if.waitrequest, r1);
                chk("clr mem_chipselect", mem_chipselect, 1);
                chk("clr mem_write", mem_write, 1);
                chk("clr mem_address", mem_address, cidx);
                chk("clr mem_byteenable", mem_byteenable, 4'hF);
                chk("clr mem_writedata", mem_writedata, 0);
            end
            ref_mem[cidx] = 32'h0;
            cidx++;
            exp_done = 1'b0;
            if (cidx == DEPTH) begin
                mclr     = 1'b0;
                cidx     = 0;
                exp_done = 1'b1;
            end
        end else begin
            exp_done = 1'b0;
            g = -1;
            if (r0 && r1) g = prio;
            else if (r0)  g = 0;
            else if (r1)  g = 1;
            wr = (g == 0) ? m0_if.write : m1_if.write;
            if (mvalid) begin
                chk("m0_waitrequest", m0_if.waitrequest, r0 && g != 0);
                chk("m1_waitrequest", m1_if.waitrequest, r1 && g != 1);
                chk("mem_chipselect", mem_chipselect, g >= 0);
                chk("mem_write", mem_write, g >= 0 && wr);
            end
            if (g >= 0) begin
                a  = (g == 0) ? m0_if.address    : m1_if.address;
                be = (g == 0) ? m0_if.byteenable : m1_if.byteenable;
                wd = (g == 0) ? m0_if.writedata  : m1_if.writedata;
                if (mvalid) chk("mem_address", mem_address, a);
                if (wr) begin
                    if (mvalid) begin
                        chk("mem_byteenable", mem_byteenable, be);
                        chk("mem_writedata", mem_writedata, wd);
                    end
                    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                    ref_mem[a] = (ref_mem[a] & ~mask) | (wd & mask);
                end else begin
                    it.owner = g;
                    it.data  = ref_mem[a];
                    rq.push_back(it);
                end
                prio = 1 - g;
            end
            if (clear_start) begin
                mclr = 1'b1;
                cidx = 0;
            end
        end
        if (reset) begin
            mclr     = 1'b0;
            cidx     = 0;
            prio     = 0;
            exp_done = 1'b0;
            rq.delete();
            mvalid   = 1'b1;
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_step();
    endtask

    task automatic tick();
        run_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic m0_rd, m0_wr; logic [AW-1:0] m0_a; logic [3:0] m0_be; logic [31:0] m0_wd;
        logic m1_rd, m1_wr; logic [AW-1:0] m1_a; logic [3:0] m1_be; logic [31:0] m1_wd;
        logic e_w0, e_w1, e_v0, e_v1; logic [31:0] e_d;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, w0, input logic [AW-1:0] a0, input logic [3:0] b0, input logic [31:0] d0,
        input logic r1, w1, input logic [AW-1:0] a1, input logic [3:0] b1, input logic [31:0] d1,
        input logic ew0, ew1, ev0, ev1, input logic [31:0] ed);
        vec_t v;
        v.m0_rd = r0; v.m0_wr = w0; v.m0_a = a0; v.m0_be = b0; v.m0_wd = d0;
        v.m1_rd = r1; v.m1_wr = w1; v.m1_a = a1; v.m1_be = b1; v.m1_wd = d1;
        v.e_w0 = ew0; v.e_w1 = ew1; v.e_v0 = ev0; v.e_v1 = ev1; v.e_d = ed;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m0_if.read = v.m0_rd; m0_if.write = v.m0_wr; m0_if.address = v.m0_a;
        m0_if.byteenable = v.m0_be; m0_if.writedata = v.m0_wd;
        m1_if.read = v.m1_rd; m1_if.write = v.m1_wr; m1_if.address = v.m1_a;
        m1_if.byteenable = v.m1_be; m1_if.writedata = v.m1_wd;
    endtask

    task automatic idle_inputs();
        drive(mk(0, 0, 0, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
    endtask

    // Pulse clear_start with m0 reading throughout; optional second pulse mid-clear
    task automatic clear_run(input int repulse_at, input string tag);
        int nbusy, ndone, done_at;
        nbusy = 0; ndone = 0; done_at = -1;
        idle_inputs();
        m0_if.read = 1'b1; m0_if.address = 8'h03;
        for (int i = 0; i < 30; i++) begin
            clear_start = (i == 0) || (i == repulse_at);
            run_cycle();
            if (clear_busy) nbusy++;
            if (clear_busy) chk({tag, " m0 stalled"}, m0_if.waitrequest, 1);
            if (clear_done) begin ndone++; done_at = i; end
            @(posedge clk); #1;
        end
        clear_start = 1'b0;
        chk({tag, " busy cycles"}, nbusy, DEPTH);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " done cycle"}, done_at, DEPTH + 1);
    endtask

    vec_t tbl[$];
    localparam logic [31:0] P0 = 32'hCAFE_00A0;

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = pre(i);
        prio = 0; mclr = 0; cidx = 0; exp_done = 0; mvalid = 0;
        reset = 1'b1;
        clear_start = 1'b0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        run_cycle();
        chk("reset clear_busy", clear_busy, 0);
        chk("reset m0_readdatavalid", m0_if.readdatavalid, 0);
        @(posedge clk); #1;

        //        m0: rd wr addr  be    wd            m1: rd wr addr  be    wd           w0 w1 v0 v1 data
        tbl.push_back(mk(1, 0, 8'hA0, 4'hF, 0,            1, 0, 8'hA1, 4'hF, 0,            0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hA2, 4'hF, 0,            1, 0, 8'hA1, 4'hF, 0,            1, 0, 1, 0, P0 + 0));
        tbl.push_back(mk(1, 0, 8'hA2, 4'hF, 0,            1, 0, 8'hA3, 4'hF, 0,            0, 1, 0, 1, P0 + 1));
        tbl.push_back(mk(1, 0, 8'hA4, 4'hF, 0,            1, 0, 8'hA3, 4'hF, 0,            1, 0, 1, 0, P0 + 2));
        tbl.push_back(mk(1, 0, 8'hA4, 4'hF, 0,            1, 0, 8'hA5, 4'hF, 0,            0, 1, 0, 1, P0 + 3));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            1, 0, 8'hA5, 4'hF, 0,            0, 0, 1, 0, P0 + 4));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 1, P0 + 5));
        tbl.push_back(mk(0, 1, 8'h10, 4'hF, 32'hDEADBEEF, 0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h10, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            0, 1, 8'h20, 4'h5, 32'h11223344, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            1, 0, 8'h20, 4'hF, 0,            0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 1, 32'hFF22FF44));
        tbl.push_back(mk(1, 1, 8'h30, 4'hF, 32'h00000055, 0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h30, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 4'hF, 0,            0, 0, 8'h00, 4'hF, 0,            0, 0, 1, 0, 32'h00000055));
        tbl.push_back(mk(0, 1, 8'h40, 4'hF, 32'h1,        0, 1, 8'h41, 4'hF, 32'h2,        1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h40, 4'hF, 32'h1,        0, 1, 8'h42, 4'hF, 32'h3,        0, 1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            run_cycle();
            chk($sformatf("vec%0d m0_waitrequest", i), m0_if.waitrequest, tbl[i].e_w0);
            chk($sformatf("vec%0d m1_waitrequest", i), m1_if.waitrequest, tbl[i].e_w1);
            chk($sformatf("vec%0d m0_readdatavalid", i), m0_if.readdatavalid, tbl[i].e_v0);
            chk($sformatf("vec%0d m1_readdatavalid", i), m1_if.readdatavalid, tbl[i].e_v1);
            if (tbl[i].e_v0) chk($sformatf("vec%0d m0_readdata", i), m0_if.readdata, tbl[i].e_d);
            if (tbl[i].e_v1) chk($sformatf("vec%0d m1_readdata", i), m1_if.readdata, tbl[i].e_d);
            @(posedge clk); #1;
        end
        idle_inputs();
        tick();

        // Clear with m0 waiting, then again with a redundant mid-clear pulse
        clear_run(-1, "clear");
        clear_run(8, "clear repulse");

        // Every cleared word reads back as zero
        idle_inputs();
        for (int i = 0; i <= DEPTH; i++) begin
            m0_if.read    = (i < DEPTH);
            m0_if.address = AW'(i);
            run_cycle();
            if (i > 0) begin
                chk($sformatf("cleared rdv %0d", i - 1), m0_if.readdatavalid, 1);
                chk($sformatf("cleared word %0d", i - 1), m0_if.readdata, 0);
            end
            @(posedge clk); #1;
        end

        // Reset on the 5th clear cycle; m0 granted just before so m1 would be next
        idle_inputs();
        m0_if.write = 1'b1; m0_if.address = 8'h50; m0_if.writedata = 32'h77;
        clear_start = 1'b1;
        tick();
        idle_inputs();
        clear_start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 8'h01;
        m1_if.read = 1'b1; m1_if.address = 8'h02;
        run_cycle();
        chk("abort clear_busy", clear_busy, 0);
        chk("abort clear_done", clear_done, 0);
        chk("abort m0 wins", m0_if.waitrequest, 0);
        chk("abort m1 waits", m1_if.waitrequest, 1);
        @(posedge clk); #1;

        // Random traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            int k0, k1;
            k0 = $urandom_range(0, 7);
            k1 = $urandom_range(0, 7);
            m0_if.read  = (k0 inside {1, 2, 3, 7});
            m0_if.write = (k0 inside {4, 5, 7});
            m1_if.read  = (k1 inside {1, 2, 3, 7});
            m1_if.write = (k1 inside {4, 5, 7});
            m0_if.address = AW'($urandom_range(0, 31));
            m1_if.address = AW'($urandom_range(0, 31));
            m0_if.byteenable = 4'($urandom);
            m1_if.byteenable = 4'($urandom);
            m0_if.writedata = $urandom;
            m1_if.writedata = $urandom;
            clear_start = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear_start = 1'b0;
        idle_inputs();
        repeat (DEPTH + 3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
